// File: rtl/memory_sub_system_pkg.sv
// Shared widths, Hamming(12,8) constants and helpers, and the request record for memory_sub_system.
// Positions are 1-based; position p is stored in word bit p-1.
package sub_system_pkg;

    localparam int D_W_DEF = 8;
    localparam int A_W_DEF = 6;
    localparam int R_W_DEF = 12;

    localparam logic [R_W_DEF-1:0] PAR_POS_MASK = 12'h08B;  // positions 1, 2, 4, 8
    localparam logic [R_W_DEF-1:0] SYN_MASK_0   = 12'h555;  // positions with index bit 0 set
    localparam logic [R_W_DEF-1:0] SYN_MASK_1   = 12'h666;
    localparam logic [R_W_DEF-1:0] SYN_MASK_2   = 12'h878;
    localparam logic [R_W_DEF-1:0] SYN_MASK_3   = 12'hF80;

    typedef struct packed {
        logic                 we;
        logic [A_W_DEF-1:0]   addr;
        logic [D_W_DEF-1:0]   data;
    } req_t;

    function automatic logic [3:0] hamming_syndrome(input logic [R_W_DEF-1:0] w);
        return {^(w & SYN_MASK_3), ^(w & SYN_MASK_2), ^(w & SYN_MASK_1), ^(w & SYN_MASK_0)};
    endfunction

    // Data fills the non-parity positions 3,5,6,7,9,10,11,12 LSB first; parity is even.
    function automatic logic [R_W_DEF-1:0] hamming_encode(input logic [D_W_DEF-1:0] d);
        logic [R_W_DEF-1:0] w;
        logic [3:0]         s;
        w = {d[7], d[6], d[5], d[4], 1'b0, d[3], d[2], d[1], 1'b0, d[0], 1'b0, 1'b0};
        s = hamming_syndrome(w);
        w[0] = s[0];
        w[1] = s[1];
        w[3] = s[2];
        w[7] = s[3];
        return w;
    endfunction

    function automatic logic [R_W_DEF-1:0] hamming_correct(input logic [R_W_DEF-1:0] w);
        logic [R_W_DEF-1:0] c;
        logic [3:0]         s;
        c = w;
        s = hamming_syndrome(w);
        if (s != 4'd0 && s <= 4'(R_W_DEF)) begin
            c[s - 4'd1] = ~w[s - 4'd1];
        end
        return c;
    endfunction

    function automatic logic [D_W_DEF-1:0] hamming_data(input logic [R_W_DEF-1:0] w);
        return {w[11], w[10], w[9], w[8], w[6], w[5], w[4], w[2]};
    endfunction

endpackage

// File: rtl/memory_sub_system_mem_bank.sv
// mem_bank: 2^A_W x R_W array with two write and two asynchronous read ports.
// Port A write wins on an address collision; async reset clears every word.
module mem_bank #(
    parameter int A_W = 6,
    parameter int R_W = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           we_a,
    input  logic [A_W-1:0] waddr_a,
    input  logic [R_W-1:0] wdata_a,
    input  logic           we_b,
    input  logic [A_W-1:0] waddr_b,
    input  logic [R_W-1:0] wdata_b,
    input  logic [A_W-1:0] raddr_a,
    output logic [R_W-1:0] rdata_a,
    input  logic [A_W-1:0] raddr_b,
    output logic [R_W-1:0] rdata_b
);

    localparam int DEPTH = 1 << A_W;

    logic [R_W-1:0] mem_q [DEPTH];
    logic [R_W-1:0] mem_d [DEPTH];

    // NOTE: every always_comb output gets a full default first, so no path can infer a latch.
    always_comb begin
        mem_d = mem_q;
        if (we_b) mem_d[waddr_b] = wdata_b;
        if (we_a) mem_d[waddr_a] = wdata_a;
    end

    // NOTE: this array is reset on purpose: all-zero is a valid codeword, so reads after reset are clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/memory_sub_system.sv
// memory_sub_system: dual-port ECC RAM with independent per-port write/read latency pipelines.
// Define ECC_EN to enable Hamming encode/correct; otherwise data is stored zero-extended.
module memory_sub_system
    import sub_system_pkg::*;
#(
    parameter int D_W  = D_W_DEF,
    parameter int A_W  = A_W_DEF,
    parameter int R_W  = R_W_DEF,
    parameter int WL_A = 3,
    parameter int RL_A = 3,
    parameter int WL_B = 3,
    parameter int RL_B = 3
) (
    input  logic           input_clk,
    input  logic           input_rst_n,
    input  logic           input_enA,
    input  logic           input_weA,
    input  logic [A_W-1:0] input_AddA,
    input  logic [D_W-1:0] input_DinA,
    input  logic           input_enB,
    input  logic           input_weB,
    input  logic [A_W-1:0] input_AddB,
    input  logic [D_W-1:0] input_DinB,
    output logic [D_W-1:0] final_Dout_A,
    output logic [D_W-1:0] final_Dout_B
);

    function automatic logic [R_W-1:0] store_word(input logic [D_W-1:0] d);
`ifdef ECC_EN
        return hamming_encode(d);
`else
        return {{(R_W-D_W){1'b0}}, d};
`endif
    endfunction

    function automatic logic [D_W-1:0] load_data(input logic [R_W-1:0] w);
`ifdef ECC_EN
        return hamming_data(hamming_correct(w));
`else
        return w[D_W-1:0];
`endif
    endfunction

    req_t            wr_a_q [WL_A], wr_a_d [WL_A];
    req_t            wr_b_q [WL_B], wr_b_d [WL_B];
    logic [WL_A-1:0] wr_vld_a_q, wr_vld_a_d;
    logic [WL_B-1:0] wr_vld_b_q, wr_vld_b_d;
    logic [R_W-1:0]  rd_word_a_q [RL_A], rd_word_a_d [RL_A];
    logic [R_W-1:0]  rd_word_b_q [RL_B], rd_word_b_d [RL_B];
    logic [RL_A-1:0] rd_vld_a_q, rd_vld_a_d;
    logic [RL_B-1:0] rd_vld_b_q, rd_vld_b_d;
    logic [D_W-1:0]  dout_a_q, dout_a_d;
    logic [D_W-1:0]  dout_b_q, dout_b_d;
    logic [R_W-1:0]  bank_rdata_a, bank_rdata_b;

    // Reads sample the array at acceptance; the pipeline only delays the captured word.
    always_comb begin
        wr_vld_a_d[0] = input_enA;
        wr_a_d[0]     = '{we: input_weA, addr: input_AddA, data: input_DinA};
        for (int i = 1; i < WL_A; i++) begin
            wr_vld_a_d[i] = wr_vld_a_q[i-1];
            wr_a_d[i]     = wr_a_q[i-1];
        end
        wr_vld_b_d[0] = input_enB;
        wr_b_d[0]     = '{we: input_weB, addr: input_AddB, data: input_DinB};
        for (int i = 1; i < WL_B; i++) begin
            wr_vld_b_d[i] = wr_vld_b_q[i-1];
            wr_b_d[i]     = wr_b_q[i-1];
        end
        rd_vld_a_d[0]  = input_enA & ~input_weA;
        rd_word_a_d[0] = bank_rdata_a;
        for (int i = 1; i < RL_A; i++) begin
            rd_vld_a_d[i]  = rd_vld_a_q[i-1];
            rd_word_a_d[i] = rd_word_a_q[i-1];
        end
        rd_vld_b_d[0]  = input_enB & ~input_weB;
        rd_word_b_d[0] = bank_rdata_b;
        for (int i = 1; i < RL_B; i++) begin
            rd_vld_b_d[i]  = rd_vld_b_q[i-1];
            rd_word_b_d[i] = rd_word_b_q[i-1];
        end
        dout_a_d = rd_vld_a_q[RL_A-1] ? load_data(rd_word_a_q[RL_A-1]) : dout_a_q;
        dout_b_d = rd_vld_b_q[RL_B-1] ? load_data(rd_word_b_q[RL_B-1]) : dout_b_q;
    end

    always_ff @(posedge input_clk or negedge input_rst_n) begin
        if (!input_rst_n) begin
            wr_vld_a_q <= '0;
            wr_vld_b_q <= '0;
            rd_vld_a_q <= '0;
            rd_vld_b_q <= '0;
            dout_a_q   <= '0;
            dout_b_q   <= '0;
        end else begin
            wr_vld_a_q <= wr_vld_a_d;
            wr_vld_b_q <= wr_vld_b_d;
            rd_vld_a_q <= rd_vld_a_d;
            rd_vld_b_q <= rd_vld_b_d;
            dout_a_q   <= dout_a_d;
            dout_b_q   <= dout_b_d;
        end
    end

    // NOTE: payload stages carry no reset; the valid bits alone decide whether they are used.
    always_ff @(posedge input_clk) begin
        wr_a_q      <= wr_a_d;
        wr_b_q      <= wr_b_d;
        rd_word_a_q <= rd_word_a_d;
        rd_word_b_q <= rd_word_b_d;
    end

    mem_bank #(
        .A_W (A_W),
        .R_W (R_W)
    ) u_bank (
        .clk     (input_clk),
        .rst_n   (input_rst_n),
        .we_a    (wr_vld_a_q[WL_A-1] & wr_a_q[WL_A-1].we),
        .waddr_a (wr_a_q[WL_A-1].addr),
        .wdata_a (store_word(wr_a_q[WL_A-1].data)),
        .we_b    (wr_vld_b_q[WL_B-1] & wr_b_q[WL_B-1].we),
        .waddr_b (wr_b_q[WL_B-1].addr),
        .wdata_b (store_word(wr_b_q[WL_B-1].data)),
        .raddr_a (input_AddA),
        .rdata_a (bank_rdata_a),
        .raddr_b (input_AddB),
        .rdata_b (bank_rdata_b)
    );

    assign final_Dout_A = dout_a_q;
    assign final_Dout_B = dout_b_q;

endmodule

// File: tb/tb_memory_sub_system.sv
// Scoreboard bench for memory_sub_system: reads push expected data with a due cycle,
// a monitor pops and compares when each read's Dout update is due.
module tb_memory_sub_system;

    localparam int WL = 3;
    localparam int RL = 3;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0;
    logic [5:0] add_a = '0, add_b = '0;
    logic [7:0] din_a = '0, din_b = '0;
    logic [7:0] dout_a, dout_b;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t qa[$];
    exp_t qb[$];

    memory_sub_system #(
        .D_W(8), .A_W(6), .R_W(12), .WL_A(WL), .RL_A(RL), .WL_B(WL), .RL_B(RL)
    ) dut (
        .input_clk    (clk),
        .input_rst_n  (rst_n),
        .input_enA    (en_a),
        .input_weA    (we_a),
        .input_AddA   (add_a),
        .input_DinA   (din_a),
        .input_enB    (en_b),
        .input_weB    (we_b),
        .input_AddB   (add_b),
        .input_DinB   (din_b),
        .final_Dout_A (dout_a),
        .final_Dout_B (dout_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got 0x%02h, expected 0x%02h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares each read when its Dout update has landed.
    always @(negedge clk) begin
        if (qa.size() > 0 && qa[0].due <= cyc) begin
            exp_t e;
            e = qa.pop_front();
            check("dout_a", dout_a, e.data);
        end
        if (qb.size() > 0 && qb[0].due <= cyc) begin
            exp_t e;
            e = qb.pop_front();
            check("dout_b", dout_b, e.data);
        end
    end

    // Called at a negedge; the request is accepted on edge cyc+1 and Dout lands on edge cyc+1+RL.
    task automatic wr_a(input logic [5:0] a, input logic [7:0] d);
        en_a = 1'b1; we_a = 1'b1; add_a = a; din_a = d;
    endtask

    task automatic wr_b(input logic [5:0] a, input logic [7:0] d);
        en_b = 1'b1; we_b = 1'b1; add_b = a; din_b = d;
    endtask

    task automatic rd_a(input logic [5:0] a, input logic [7:0] exp);
        en_a = 1'b1; we_a = 1'b0; add_a = a;
        qa.push_back('{data: exp, due: cyc + 1 + RL});
    endtask

    task automatic rd_b(input logic [5:0] a, input logic [7:0] exp);
        en_b = 1'b1; we_b = 1'b0; add_b = a;
        qb.push_back('{data: exp, due: cyc + 1 + RL});
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            en_a = 1'b0;
            en_b = 1'b0;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && (qa.size() + qb.size()) > 0; k++) step(1);
        tests++;
        if (qa.size() + qb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d reads still pending, expected 0", qa.size() + qb.size());
            qa.delete();
            qb.delete();
        end
    endtask

    initial begin
        step(3);
        check("reset_dout_a", dout_a, 8'h00);
        check("reset_dout_b", dout_b, 8'h00);
        rst_n = 1'b1;

        // Full sweep through port A.
        for (int i = 0; i < 64; i++) begin
            wr_a(6'(i), 8'(i));
            step(1);
        end
        for (int i = 0; i < 64; i++) begin
            rd_a(6'(i), 8'(i));
            step(1);
        end
        drain();

        // Write commit boundary: read at t+WL sees old data, t+WL+1 sees new.
        wr_a(6'd35, 8'd120);
        step(WL);
        rd_a(6'd35, 8'd35);
        step(1);
        rd_a(6'd35, 8'd120);
        step(1);
        drain();

`ifdef ECC_EN
        dut.u_bank.mem_q[35][6] = ~dut.u_bank.mem_q[35][6];
        rd_a(6'd35, 8'd120);
        step(1);
        drain();
`endif

        // Port B write seen by port A one cycle after commit.
        wr_b(6'd25, 8'd125);
        step(WL + 1);
        rd_a(6'd25, 8'd125);
        rd_b(6'd25, 8'd125);
        step(1);
        drain();

        // Same-edge collision: port A wins.
        wr_a(6'd10, 8'hAA);
        wr_b(6'd10, 8'h55);
        step(WL + 1);
        rd_a(6'd10, 8'hAA);
        rd_b(6'd10, 8'hAA);
        step(1);
        drain();

        // Writes never disturb Dout.
        wr_a(6'd5, 8'h33);
        wr_b(6'd6, 8'h44);
        step(WL + 3);
        check("hold_a", dout_a, 8'hAA);
        check("hold_b", dout_b, 8'hAA);

        // Reset during in-flight reads.
        en_a = 1'b1; we_a = 1'b0; add_a = 6'd35;
        en_b = 1'b1; we_b = 1'b0; add_b = 6'd25;
        step(1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_a", dout_a, 8'h00);
        check("rst_async_b", dout_b, 8'h00);
        step(2);
        rst_n = 1'b1;
        wr_a(6'd7, 8'd77);
        step(1);
        for (int k = 0; k < RL + 2; k++) begin
            check("stale_a", dout_a, 8'h00);
            check("stale_b", dout_b, 8'h00);
            step(1);
        end
        rd_a(6'd7, 8'd77);
        rd_b(6'd35, 8'h00);
        step(1);
        rd_a(6'd63, 8'h00);
        rd_b(6'd25, 8'h00);
        step(1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
